// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers
// and returns each result (read data or timeout error) on a valid/ready response stream.
module apb_cmd_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                cmd_ready_q, cmd_ready_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Next-state logic; every output flop is loaded from the decode of the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_inc     = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Completion wins over a timeout hitting in the same cycle
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master (ADDR_W=8, DATA_W=32, TIMEOUT=16).
module tb_apb_cmd_master;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int n_checks = 0;
  int n_pass   = 0;

  apb_cmd_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one clock; outputs are then sampled and inputs changed 1ns after the edge
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Offer one command for a single edge while the DUT is idle
  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    #3;
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
    else n_pass++;
    n_checks++;
    if (PADDR !== 8'h00 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_data: PADDR=%h PWDATA=%h rsp_rdata=%h expected all 0", PADDR, PWDATA, rsp_rdata);
    else n_pass++;
    tick();
    tick();
    PRESETn = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write_no_wait();
    PREADY    = 1'b1;
    rsp_ready = 1'b0;
    issue(1'b1, 8'h04, 32'h0000_0010);
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, cmd_ready} !== 4'b1010 || PADDR !== 8'h04 || PWDATA !== 32'h10)
      $display("FAIL wr_setup: PSEL/PENABLE/PWRITE/cmd_ready=%b PADDR=%h PWDATA=%h expected 1010 04 00000010",
               {PSEL, PENABLE, PWRITE, cmd_ready}, PADDR, PWDATA);
    else n_pass++;
    tick();
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110)
      $display("FAIL wr_access: PSEL/PENABLE/rsp_valid=%b expected 110", {PSEL, PENABLE, rsp_valid});
    else n_pass++;
    tick();
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 32'h0)
      $display("FAIL wr_resp: PSEL/PENABLE/rsp_valid/rsp_err=%b rdata=%h expected 0010 00000000",
               {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL wr_idle: rsp_valid/cmd_ready=%b expected 01", {rsp_valid, cmd_ready});
    else n_pass++;
  endtask

  task automatic test_read_waits();
    PREADY = 1'b0;
    PRDATA = 32'hFFFF_FFFF;
    issue(1'b0, 8'h0C, 32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 8'h0C || PWRITE !== 1'b0)
        $display("FAIL rd_wait%0d: PSEL/PENABLE/rsp_valid=%b PADDR=%h PWRITE=%b expected 110 0c 0",
                 i, {PSEL, PENABLE, rsp_valid}, PADDR, PWRITE);
      else n_pass++;
      tick();
    end
    PREADY = 1'b1;
    PRDATA = 32'h0000_00A5;
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110 || PADDR !== 8'h0C)
      $display("FAIL rd_last_access: PSEL/PENABLE/rsp_valid=%b PADDR=%h expected 110 0c",
               {PSEL, PENABLE, rsp_valid}, PADDR);
    else n_pass++;
    tick();
    PREADY = 1'b0;
    PRDATA = 32'h1234_5678;
    n_checks++;
    if ({PSEL, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'hA5)
      $display("FAIL rd_resp: PSEL/rsp_valid/rsp_err=%b rdata=%h expected 010 000000a5",
               {PSEL, rsp_valid, rsp_err}, rsp_rdata);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout(input logic rise_on_last);
    PREADY = 1'b0;
    PRDATA = 32'h0000_DEAD;
    issue(1'b0, 8'h10, 32'h0);
    tick();
    for (int i = 1; i < 16; i++) tick();
    n_checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110)
      $display("FAIL to_cycle16_%0d: PSEL/PENABLE/rsp_valid=%b expected 110", rise_on_last,
               {PSEL, PENABLE, rsp_valid});
    else n_pass++;
    if (rise_on_last) begin
      PREADY = 1'b1;
      PRDATA = 32'h0000_5A5A;
    end
    tick();
    PREADY = 1'b0;
    n_checks++;
    if (rise_on_last) begin
      if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010 || rsp_rdata !== 32'h5A5A)
        $display("FAIL to_late_ready: PSEL/PENABLE/rsp_valid/rsp_err=%b rdata=%h expected 0010 00005a5a",
                 {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
      else n_pass++;
    end else begin
      if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0011 || rsp_rdata !== 32'h0)
        $display("FAIL to_abort: PSEL/PENABLE/rsp_valid/rsp_err=%b rdata=%h expected 0011 00000000",
                 {PSEL, PENABLE, rsp_valid, rsp_err}, rsp_rdata);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    PREADY = 1'b1;
    issue(1'b1, 8'h20, 32'h0000_1234);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h24;
    cmd_wdata = 32'h0;
    PRDATA    = 32'h0000_0077;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_err, cmd_ready, PSEL} !== 4'b1000 || rsp_rdata !== 32'h0 || PADDR !== 8'h20)
        $display("FAIL bp_hold%0d: rsp_valid/rsp_err/cmd_ready/PSEL=%b rdata=%h PADDR=%h expected 1000 00000000 20",
                 i, {rsp_valid, rsp_err, cmd_ready, PSEL}, rsp_rdata, PADDR);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready, PSEL} !== 3'b010)
      $display("FAIL bp_release: rsp_valid/cmd_ready/PSEL=%b expected 010", {rsp_valid, cmd_ready, PSEL});
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 8'h24)
      $display("FAIL bp_second_setup: PSEL/PENABLE/PWRITE=%b PADDR=%h expected 100 24",
               {PSEL, PENABLE, PWRITE}, PADDR);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h77)
      $display("FAIL bp_second_resp: rsp_valid/rsp_err=%b rdata=%h expected 10 00000077",
               {rsp_valid, rsp_err}, rsp_rdata);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  addrs [4] = '{8'h00, 8'h04, 8'h08, 8'h08};
    logic [31:0] datas [4] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
    PREADY    = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = addrs[0];
    cmd_wdata = datas[0];
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== addrs[k] || PWDATA !== datas[k])
        $display("FAIL b2b_setup%0d: PSEL/PENABLE/PWRITE=%b PADDR=%h PWDATA=%h expected 101 %h %h",
                 k, {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, addrs[k], datas[k]);
      else n_pass++;
      tick();
      n_checks++;
      if ({PSEL, PENABLE} !== 2'b11 || PADDR !== addrs[k])
        $display("FAIL b2b_access%0d: PSEL/PENABLE=%b PADDR=%h expected 11 %h", k, {PSEL, PENABLE}, PADDR, addrs[k]);
      else n_pass++;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_err, PSEL, cmd_ready} !== 4'b1000 || rsp_rdata !== 32'h0)
        $display("FAIL b2b_resp%0d: rsp_valid/rsp_err/PSEL/cmd_ready=%b rdata=%h expected 1000 00000000",
                 k, {rsp_valid, rsp_err, PSEL, cmd_ready}, rsp_rdata);
      else n_pass++;
      if (k < 3) begin
        cmd_addr  = addrs[k+1];
        cmd_wdata = datas[k+1];
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      n_checks++;
      if ({cmd_ready, rsp_valid, PSEL} !== 3'b100)
        $display("FAIL b2b_idle%0d: cmd_ready/rsp_valid/PSEL=%b expected 100", k, {cmd_ready, rsp_valid, PSEL});
      else n_pass++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    PREADY = 1'b0;
    issue(1'b0, 8'h30, 32'h0);
    tick();
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b000001 || PADDR !== 8'h00 ||
        rsp_rdata !== 32'h0)
      $display("FAIL rst_mid: PSEL/PENABLE/PWRITE/rsp_valid/rsp_err/cmd_ready=%b PADDR=%h rdata=%h expected 000001 00 00000000",
               {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, PADDR, rsp_rdata);
    else n_pass++;
    tick();
    PRESETn = 1'b1;
    tick();
    PREADY = 1'b1;
    PRDATA = 32'h0000_00C3;
    issue(1'b0, 8'h08, 32'h0);
    tick();
    tick();
    n_checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hC3)
      $display("FAIL rst_recover: rsp_valid/rsp_err=%b rdata=%h expected 10 000000c3", {rsp_valid, rsp_err}, rsp_rdata);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_no_wait();
    test_read_waits();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
